// File: rtl/x68_video_pkg.sv
// ---------------------------------------------------------------------------
// x68_video_pkg
// Shared definitions for the X68000 video line-buffer path.
//   LRAM_AW / LRAM_DW : line RAM address and pixel widths
//   pixel_t           : one 16-bit GRBI (5:5:5:1) pixel
//   fill_state_e      : line-fill FSM states
//   HDOTS_CLAMP       : widest line in 8-dot units (128 * 8 = 1024 pixels)
//   npix_of()         : active width in 8-dot units -> pixel count
// ---------------------------------------------------------------------------
package x68_video_pkg;

  localparam int LRAM_AW = 10;
  localparam int LRAM_DW = 16;

  typedef logic [LRAM_DW-1:0] pixel_t;

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_REQ  = 2'd1,
    FILL_WR   = 2'd2
  } fill_state_e;

  localparam logic [7:0] HDOTS_CLAMP = 8'd128;

  // One extra bit over LRAM_AW so a full 1024-pixel line is representable.
  function automatic logic [LRAM_AW:0] npix_of(input logic [7:0] hdots);
    logic [7:0] clamped;
    clamped = (hdots > HDOTS_CLAMP) ? HDOTS_CLAMP : hdots;
    return {clamped, 3'b000};
  endfunction

endpackage

// File: rtl/lram_fill_if.sv
// ---------------------------------------------------------------------------
// lram_fill_if
// Pixel-source fetch handshake between the line-buffer writer and the
// upstream pixel source.
//   src_req  : fetch request (held with src_addr until acknowledged)
//   src_addr : {line[9:0], x[9:0]}
//   src_ack  : data valid, only meaningful while src_req=1
//   src_data : fetched GRBI pixel
// Modports: master = requester (lram_fill), slave = pixel source.
// ---------------------------------------------------------------------------
interface lram_fill_if;

  logic                      src_req;
  logic [19:0]               src_addr;
  logic                      src_ack;
  x68_video_pkg::pixel_t     src_data;

  modport master (
    output src_req,
    output src_addr,
    input  src_ack,
    input  src_data
  );

  modport slave (
    input  src_req,
    input  src_addr,
    output src_ack,
    output src_data
  );

endinterface

// File: rtl/lram_fill.sv
// ---------------------------------------------------------------------------
// lram_fill
// Producer side of the ping-pong line RAM. On each HCOMP line-start pulse it
// fetches one line of pixels from the pixel source (req/ack) and writes them
// into the bank that scan-out has just released.
// Ports:
//   gclk, rst          : video clock, synchronous active-high reset
//   HCOMP, VPSTART     : line start / first line of frame
//   LRAMSEL            : bank being displayed (pre-toggle value at HCOMP)
//   hdots              : active width in 8-dot units (clamped to 128)
//   src                : pixel-source handshake (lram_fill_if.master)
//   wr_en/bank/addr/data : line RAM write port
//   busy, line         : fill status, line number being filled
//   ovr_cnt            : overrun counter
// Build option: define LRAM_FILL_OVR_EN to build the saturating overrun
// counter; otherwise ovr_cnt is tied to zero.
// ---------------------------------------------------------------------------
module lram_fill
  import x68_video_pkg::*;
(
  input  logic               gclk,
  input  logic               rst,
  input  logic               HCOMP,
  input  logic               VPSTART,
  input  logic               LRAMSEL,
  input  logic [7:0]         hdots,
  lram_fill_if.master        src,
  output logic               wr_en,
  output logic               wr_bank,
  output logic [LRAM_AW-1:0] wr_addr,
  output pixel_t             wr_data,
  output logic               busy,
  output logic [LRAM_AW-1:0] line,
  output logic [7:0]         ovr_cnt
);

  fill_state_e        state_q, state_d;
  logic [LRAM_AW:0]   x_q, x_d;
  logic [LRAM_AW:0]   npix_q, npix_d;
  logic [LRAM_AW-1:0] line_q, line_d;
  logic               bank_q, bank_d;
  logic               src_req_q, src_req_d;
  logic [19:0]        src_addr_q, src_addr_d;
  logic               wr_en_q, wr_en_d;
  logic [LRAM_AW-1:0] wr_addr_q, wr_addr_d;
  pixel_t             wr_data_q, wr_data_d;
  logic               busy_q, busy_d;

  // Next-state and next-output computation for the fill FSM.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    npix_d    = npix_q;
    line_d    = line_q;
    bank_d    = bank_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (HCOMP) begin
      // Line start wins in every state: a fill still running is abandoned and
      // any ack arriving in this cycle is dropped. A write already on the
      // output registers this cycle completes to the old bank/address.
      bank_d = LRAMSEL;
      line_d = VPSTART ? 10'd0 : (line_q + 10'd1);
      x_d    = 11'd0;
      npix_d = npix_of(hdots);
      state_d = (npix_d == 11'd0) ? FILL_IDLE : FILL_REQ;
    end else begin
      case (state_q)
        FILL_IDLE: state_d = FILL_IDLE;
        FILL_REQ: begin
          if (src.src_ack) begin
            state_d   = FILL_WR;
            wr_en_d   = 1'b1;
            wr_addr_d = x_q[LRAM_AW-1:0];
            wr_data_d = src.src_data;
          end else begin
            state_d = FILL_REQ;
          end
        end
        FILL_WR: begin
          x_d = x_q + 11'd1;
          if (x_d < npix_q) begin
            state_d = FILL_REQ;
          end else begin
            state_d = FILL_IDLE;
          end
        end
        default: state_d = FILL_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they are registered and
    // src_req never depends combinationally on src_ack.
    src_req_d  = (state_d == FILL_REQ);
    busy_d     = (state_d != FILL_IDLE);
    src_addr_d = src_req_d ? {line_d, x_d[LRAM_AW-1:0]} : src_addr_q;
  end

  // State and output registers.
  always_ff @(posedge gclk) begin
    if (rst) begin
      state_q    <= FILL_IDLE;
      x_q        <= 11'd0;
      npix_q     <= 11'd0;
      line_q     <= 10'd0;
      bank_q     <= 1'b0;
      src_req_q  <= 1'b0;
      src_addr_q <= 20'd0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 10'd0;
      wr_data_q  <= 16'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      npix_q     <= npix_d;
      line_q     <= line_d;
      bank_q     <= bank_d;
      src_req_q  <= src_req_d;
      src_addr_q <= src_addr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
    end
  end

`ifdef LRAM_FILL_OVR_EN
  logic [7:0] ovr_cnt_q, ovr_cnt_d;

  // Count line starts that arrive while a fill is still running; saturate.
  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (HCOMP && busy_q && (ovr_cnt_q != 8'hFF)) begin
      ovr_cnt_d = ovr_cnt_q + 8'd1;
    end else begin
      ovr_cnt_d = ovr_cnt_q;
    end
  end

  // Overrun counter register.
  always_ff @(posedge gclk) begin
    if (rst) begin
      ovr_cnt_q <= 8'd0;
    end else begin
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign ovr_cnt = ovr_cnt_q;
`else
  assign ovr_cnt = 8'd0;
`endif

  assign src.src_req  = src_req_q;
  assign src.src_addr = src_addr_q;
  assign wr_en        = wr_en_q;
  assign wr_bank      = bank_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign busy         = busy_q;
  assign line         = line_q;

endmodule

// File: tb/tb_lram_fill.sv
// ---------------------------------------------------------------------------
// tb_lram_fill
// Directed, table-driven bench for lram_fill. Each table row starts one line
// and a small source model acks requests after a fixed wait; every write is
// compared against the expected bank/address/pixel. Hand-written sequences
// cover overrun (HCOMP while busy) and reset during an open request.
// Works with LRAM_FILL_OVR_EN defined or undefined.
// ---------------------------------------------------------------------------
module tb_lram_fill;
  import x68_video_pkg::*;

  logic        gclk = 1'b0;
  logic        rst;
  logic        HCOMP;
  logic        VPSTART;
  logic        LRAMSEL;
  logic [7:0]  hdots;
  logic        wr_en;
  logic        wr_bank;
  logic [9:0]  wr_addr;
  pixel_t      wr_data;
  logic        busy;
  logic [9:0]  line;
  logic [7:0]  ovr_cnt;

  lram_fill_if sif ();

  lram_fill dut (
    .gclk    (gclk),
    .rst     (rst),
    .HCOMP   (HCOMP),
    .VPSTART (VPSTART),
    .LRAMSEL (LRAMSEL),
    .hdots   (hdots),
    .src     (sif),
    .wr_en   (wr_en),
    .wr_bank (wr_bank),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .line    (line),
    .ovr_cnt (ovr_cnt)
  );

  always #5 gclk = ~gclk;

`ifdef LRAM_FILL_OVR_EN
  localparam logic [7:0] OVR_EXP = 8'd1;
`else
  localparam logic [7:0] OVR_EXP = 8'd0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       lramsel;
    logic       vpstart;
    logic [7:0] hdots;
    int         wait_n;
    int         exp_npix;
    logic [9:0] exp_line;
    logic       exp_bank;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Source pixel pattern: unique per (line, x); equals x on line 0.
  function automatic logic [15:0] pix(input logic [9:0] ln, input int x);
    logic [9:0] xx;
    xx = x[9:0];
    return {ln[5:0], xx};
  endfunction

  // Runs the source model and write checker from the current negedge.
  // Stops when busy falls, or after stop_after writes when stop_after > 0.
  task automatic run_fill(input int npix, input logic [9:0] ln, input logic bank,
                          input int wait_n, input int stop_after, output int writes_o);
    int  writes;
    int  acks;
    int  wcnt;
    int  last_wr;
    int  budget;
    bit  started;
    bit  done;
    logic [9:0] xw;
    writes  = 0;
    acks    = 0;
    wcnt    = 0;
    last_wr = -10;
    started = 1'b0;
    done    = 1'b0;
    budget  = npix * (wait_n + 2) + 20;
    for (int i = 0; i < budget && !done; i++) begin
      if (wr_en) begin
        chk("wr_addr", 32'(wr_addr), 32'(writes));
        chk("wr_data", 32'(wr_data), 32'(pix(ln, writes)));
        chk("wr_bank", 32'(wr_bank), 32'(bank));
        writes++;
        last_wr = i;
      end
      if (busy) started = 1'b1;
      if (sif.src_req) begin
        xw = writes[9:0];
        chk("src_addr", 32'(sif.src_addr), 32'({ln, xw}));
        chk("line", 32'(line), 32'(ln));
      end
      if (stop_after > 0 && writes == stop_after) begin
        sif.src_ack = 1'b0;
        done = 1'b1;
      end else if (started && !busy) begin
        chk("busy_fall_after_last_wr", 32'(i - last_wr), 32'd1);
        sif.src_ack = 1'b0;
        done = 1'b1;
      end else begin
        if (sif.src_req) begin
          if (wcnt == wait_n) begin
            sif.src_ack  = 1'b1;
            sif.src_data = pix(ln, writes);
            acks++;
            wcnt = 0;
          end else begin
            sif.src_ack = 1'b0;
            wcnt++;
          end
        end else begin
          sif.src_ack = 1'b0;
          wcnt = 0;
        end
        @(negedge gclk);
      end
    end
    chk("fill_timeout", 32'(done), 32'd1);
    chk("one_wr_per_ack", 32'(writes), 32'(acks));
    writes_o = writes;
  endtask

  // Issue one HCOMP with the row's controls and check the resulting line.
  task automatic fill_line(input vec_t v);
    int w;
    HCOMP   = 1'b1;
    VPSTART = v.vpstart;
    LRAMSEL = v.lramsel;
    hdots   = v.hdots;
    @(negedge gclk);
    HCOMP   = 1'b0;
    VPSTART = 1'b0;
    chk("req_at_t1", 32'(sif.src_req), 32'(v.exp_npix > 0));
    if (v.exp_npix > 0) begin
      chk("first_src_addr", 32'(sif.src_addr), 32'({v.exp_line, 10'd0}));
      chk("bank_at_start", 32'(wr_bank), 32'(v.exp_bank));
      run_fill(v.exp_npix, v.exp_line, v.exp_bank, v.wait_n, 0, w);
      chk("write_count", 32'(w), 32'(v.exp_npix));
    end else begin
      for (int k = 0; k < 4; k++) begin
        chk("zero_width_busy", 32'(busy), 32'd0);
        chk("zero_width_req", 32'(sif.src_req), 32'd0);
        @(negedge gclk);
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    vecs[0] = '{1'b0, 1'b1, 8'd2,   0, 16,   10'd0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'd2,   0, 16,   10'd1, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 8'd200, 0, 1024, 10'd2, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 8'd0,   0, 0,    10'd0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 8'd1,   5, 8,    10'd0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 8'd129, 0, 1024, 10'd1, 1'b0};

    rst          = 1'b1;
    HCOMP        = 1'b0;
    VPSTART      = 1'b0;
    LRAMSEL      = 1'b0;
    hdots        = 8'd0;
    sif.src_ack  = 1'b0;
    sif.src_data = 16'd0;
    repeat (3) @(negedge gclk);
    rst = 1'b0;
    @(negedge gclk);

    // Reset state
    chk("rst_src_req",  32'(sif.src_req),  32'd0);
    chk("rst_src_addr", 32'(sif.src_addr), 32'd0);
    chk("rst_wr_en",    32'(wr_en),        32'd0);
    chk("rst_wr_bank",  32'(wr_bank),      32'd0);
    chk("rst_wr_addr",  32'(wr_addr),      32'd0);
    chk("rst_wr_data",  32'(wr_data),      32'd0);
    chk("rst_busy",     32'(busy),         32'd0);
    chk("rst_line",     32'(line),         32'd0);
    chk("rst_ovr_cnt",  32'(ovr_cnt),      32'd0);

    // Table-driven lines
    for (int i = 0; i < 6; i++) begin
      fill_line(vecs[i]);
      @(negedge gclk);
    end

    // Overrun: second HCOMP after 10 pixels, with an ack in the same cycle
    HCOMP   = 1'b1;
    VPSTART = 1'b1;
    LRAMSEL = 1'b0;
    hdots   = 8'd2;
    @(negedge gclk);
    HCOMP   = 1'b0;
    VPSTART = 1'b0;
    run_fill(16, 10'd0, 1'b0, 0, 10, w);
    chk("ovr_pre_writes", 32'(w), 32'd10);
    @(negedge gclk);
    chk("ovr_pre_req",  32'(sif.src_req),  32'd1);
    chk("ovr_pre_addr", 32'(sif.src_addr), 32'h0000A);
    HCOMP        = 1'b1;
    LRAMSEL      = 1'b1;
    hdots        = 8'd1;
    sif.src_ack  = 1'b1;
    sif.src_data = 16'hDEAD;
    @(negedge gclk);
    HCOMP       = 1'b0;
    sif.src_ack = 1'b0;
    chk("ovr_ack_dropped", 32'(wr_en),        32'd0);
    chk("ovr_req",         32'(sif.src_req),  32'd1);
    chk("ovr_addr",        32'(sif.src_addr), 32'h00400);
    chk("ovr_busy",        32'(busy),         32'd1);
    chk("ovr_bank",        32'(wr_bank),      32'd1);
    chk("ovr_line",        32'(line),         32'd1);
    chk("ovr_cnt",         32'(ovr_cnt),      32'(OVR_EXP));
    run_fill(8, 10'd1, 1'b1, 0, 0, w);
    chk("ovr_new_writes", 32'(w), 32'd8);
    chk("ovr_cnt_after",  32'(ovr_cnt), 32'(OVR_EXP));
    @(negedge gclk);

    // Reset while a request is open
    HCOMP   = 1'b1;
    LRAMSEL = 1'b1;
    hdots   = 8'd2;
    @(negedge gclk);
    HCOMP = 1'b0;
    chk("rstmid_req",  32'(sif.src_req), 32'd1);
    chk("rstmid_line", 32'(line),        32'd2);
    rst = 1'b1;
    @(negedge gclk);
    rst = 1'b0;
    chk("rstmid_req_drop", 32'(sif.src_req),  32'd0);
    chk("rstmid_busy",     32'(busy),         32'd0);
    chk("rstmid_line0",    32'(line),         32'd0);
    chk("rstmid_addr",     32'(sif.src_addr), 32'd0);
    chk("rstmid_bank",     32'(wr_bank),      32'd0);
    chk("rstmid_ovr",      32'(ovr_cnt),      32'd0);
    sif.src_ack  = 1'b1;
    sif.src_data = 16'h1234;
    for (int k = 0; k < 3; k++) begin
      @(negedge gclk);
      chk("late_ack_no_wr",  32'(wr_en),       32'd0);
      chk("late_ack_no_req", 32'(sif.src_req), 32'd0);
    end
    sif.src_ack = 1'b0;
    @(negedge gclk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lram_fill.md
# lram_fill

Line-buffer writer for the X68000 video path: the producer side of the ping-pong line RAM consumed by the video sync/scan-out block. On each line-start pulse it fetches one line of 16-bit GRBI pixels from an upstream pixel source via a req/ack handshake. It writes them into the bank that scan-out has just released, so the next line is ready before it is displayed.

## Interface
- LRAM_AW, 10, line RAM address width (1024 pixels per bank)
- LRAM_DW, 16, pixel width (GRBI 5:5:5:1)
- gclk  in  1  video clock, 80 MHz
- rst  in  1  synchronous reset, active-high
- HCOMP  in  1  one-cycle line-start pulse from scan-out
- VPSTART  in  1  coincides with HCOMP on the first line of a frame
- LRAMSEL  in  1  bank currently displayed, pre-toggle value during HCOMP
- hdots  in  8  active width in 8-dot units; values above 128 clamp to 128
- src_req  out  1  pixel fetch request
- src_addr  out  20  {line[9:0], x[9:0]}
- src_ack  in  1  data valid; counted only when src_req=1
- src_data  in  16  pixel, valid with src_ack
- wr_en  out  1  line RAM write strobe
- wr_bank  out  1  target bank
- wr_addr  out  10  pixel index x
- wr_data  out  16  pixel
- busy  out  1  fill in progress
- line  out  10  line number being filled
- ovr_cnt  out  8  overrun count; see Configuration

## Operation
- FSM states: IDLE, REQ, WR.
- IDLE + HCOMP:
  - wr_bank ← LRAMSEL sampled in the HCOMP cycle. This is the bank scan-out leaves on that edge.
  - line ← 0 if VPSTART, else line+1. Wraps 1023→0.
  - x ← 0.
  - npix ← min(hdots,128)×8.
  - Go to REQ. If npix=0, stay in IDLE and leave busy at 0.
- REQ:
  - src_req=1, src_addr={line,x}; both held stable until ack.
  - On src_ack: capture src_data and go to WR.
- WR:
  - wr_en=1 for one cycle with wr_addr=x and wr_data=captured pixel; src_req=0.
  - Then x+1. Return to REQ if x+1<npix, else go to IDLE.
- busy=1 in REQ and WR.
- HCOMP while busy (overrun):
  - Abort the current line and start the new one per the IDLE+HCOMP rules in the same cycle.
  - A pending request is withdrawn without ack. An src_ack in the HCOMP cycle is discarded.
  - A WR in progress in that cycle still completes its write to the old bank/address.
  - Unwritten pixels of the aborted line keep their stale contents.
- Width arithmetic: x is 11 bits internally so npix=1024 terminates; wr_addr=x[9:0].

## Timing
- Reset values: src_req 0, src_addr 0, wr_en 0, wr_bank 0, wr_addr 0, wr_data 0, busy 0, line 0, ovr_cnt 0. State is IDLE.
- rst mid-transaction drops src_req on the next edge. A later src_ack is ignored.
- HCOMP at cycle t → src_req=1 at t+1.
- src_ack at cycle a → wr_en at a+1 → next src_req at a+2.
- Zero-wait source gives 2 cycles per pixel: 1024 px = 2048 gclk = 25.6 µs, which fits within a 31 kHz line.
- All outputs are registered. No combinational path from src_ack to src_req.

## Configuration
- LRAM_FILL_OVR_EN defined: ovr_cnt increments (saturating at 255) on each HCOMP that arrives while busy=1, and clears on rst.
- LRAM_FILL_OVR_EN undefined: ovr_cnt is tied to 0 and no counter logic is built.
- Abort/restart behaviour is identical in both builds.

## Structure
- Shared package x68_video_pkg holds:
  - LRAM_AW and LRAM_DW
  - the pixel typedef (16-bit GRBI)
  - the fill FSM state enum
  - the npix clamp constant 128
- Single flat module; no sub-module is warranted.

## Test plan
- rst, then HCOMP+VPSTART with LRAMSEL=0, hdots=2, zero-wait ack returning data=x → 16 writes on bank 0, addr 0..15, data 0..15, line=0. busy falls after the write to addr 15.
- Next HCOMP with LRAMSEL=1 (no VPSTART) → line=1, wr_bank=1, src_addr=0x00400 for the first request.
- hdots=200 → exactly 1024 writes, last wr_addr=1023, then IDLE. hdots=0 → no src_req and busy stays 0.
- Source holding ack for 5 cycles per pixel → src_addr stable across the wait and exactly one wr_en per ack.
- Second HCOMP after 10 pixels with LRAM_FILL_OVR_EN defined → src_req withdrawn, new line restarts at x=0, ovr_cnt=1. With the macro undefined, ovr_cnt stays 0.
- rst asserted while src_req=1 → src_req=0 next cycle, later src_ack produces no wr_en, and line=0.
